// File: rtl/segment7_pkg.sv
// Shared types and constants for the seven-segment decoder.
// Patterns are active-high, bit order gfedcba (seg[0]=a ... seg[6]=g).
package segment7_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_OFF = 7'h00;
    localparam seg_t SEG_ALL = 7'h7F;

    localparam seg_t SEG_0 = 7'h3F;
    localparam seg_t SEG_1 = 7'h06;
    localparam seg_t SEG_2 = 7'h5B;
    localparam seg_t SEG_3 = 7'h4F;
    localparam seg_t SEG_4 = 7'h66;
    localparam seg_t SEG_5 = 7'h6D;
    localparam seg_t SEG_6 = 7'h7D;
    localparam seg_t SEG_7 = 7'h07;
    localparam seg_t SEG_8 = 7'h7F;
    localparam seg_t SEG_9 = 7'h6F;
    localparam seg_t SEG_A = 7'h77;
    localparam seg_t SEG_B = 7'h7C;
    localparam seg_t SEG_C = 7'h39;
    localparam seg_t SEG_D = 7'h5E;
    localparam seg_t SEG_E = 7'h79;
    localparam seg_t SEG_F = 7'h71;

    function automatic logic code_is_hex(input logic [3:0] code);
        return code > 4'd9;
    endfunction

endpackage

// File: rtl/segment7_rom.sv
// Combinational 4-bit code to active-high segment decoder; latency 0, no backpressure.
// SEGMENT7_HEX_EN selects A-F glyphs for codes 10-15; otherwise those codes go dark.
module segment7_rom
    import segment7_pkg::*;
(
    input  logic [3:0] code,
    output seg_t       pattern
);

    always_comb begin
        pattern = SEG_OFF;
        case (code)
            4'd0:    pattern = SEG_0;
            4'd1:    pattern = SEG_1;
            4'd2:    pattern = SEG_2;
            4'd3:    pattern = SEG_3;
            4'd4:    pattern = SEG_4;
            4'd5:    pattern = SEG_5;
            4'd6:    pattern = SEG_6;
            4'd7:    pattern = SEG_7;
            4'd8:    pattern = SEG_8;
            4'd9:    pattern = SEG_9;
`ifdef SEGMENT7_HEX_EN
            4'd10:   pattern = SEG_A;
            4'd11:   pattern = SEG_B;
            4'd12:   pattern = SEG_C;
            4'd13:   pattern = SEG_D;
            4'd14:   pattern = SEG_E;
            4'd15:   pattern = SEG_F;
`endif
            default: pattern = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/segment7.sv
// Registered seven-segment driver with lamp test, blanking and optional polarity inversion.
// Latency: seg/err update one edge after the held digit; no backpressure. Macro: SEGMENT7_HEX_EN.
module segment7
    import segment7_pkg::*;
#(
    parameter int ACTIVE_LOW = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] bcd,
    input  logic       en,
    input  logic       blank,
    input  logic       lamp_test,
    output logic [6:0] seg,
    output logic       err
);

    localparam seg_t SEG_RST = (ACTIVE_LOW != 0) ? SEG_ALL : SEG_OFF;

    logic [3:0] digit_q, digit_d;
    seg_t       seg_q, seg_d;
    logic       err_q, err_d;
    seg_t       rom_pattern;
    seg_t       sel_pattern;

    segment7_rom u_rom (
        .code    (digit_q),
        .pattern (rom_pattern)
    );

    always_comb begin
        digit_d = digit_q;
        if (en) begin
            digit_d = bcd;
        end

        // Polarity is applied last so lamp test and blank mean the same thing on either board type.
        sel_pattern = rom_pattern;
        if (lamp_test) begin
            sel_pattern = SEG_ALL;
        end else if (blank) begin
            sel_pattern = SEG_OFF;
        end

        seg_d = (ACTIVE_LOW != 0) ? ~sel_pattern : sel_pattern;
        err_d = code_is_hex(digit_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digit_q <= 4'd0;
            seg_q   <= SEG_RST;
            err_q   <= 1'b0;
        end else begin
            digit_q <= digit_d;
            seg_q   <= seg_d;
            err_q   <= err_d;
        end
    end

    assign seg = seg_q;
    assign err = err_q;

endmodule

// File: tb/tb_segment7.sv
// Directed scoreboard bench for segment7: one active-high and one active-low instance share inputs.
module tb_segment7;

    logic       clk;
    logic       rst;
    logic [3:0] bcd;
    logic       en;
    logic       blank;
    logic       lamp_test;
    logic [6:0] seg_hi, seg_lo;
    logic       err_hi, err_lo;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [6:0] seg;
        logic       err;
    } exp_t;

    exp_t       sb_q[$];
    logic [3:0] model_digit;

    segment7 #(.ACTIVE_LOW(0)) u_hi (
        .clk(clk), .rst(rst), .bcd(bcd), .en(en), .blank(blank),
        .lamp_test(lamp_test), .seg(seg_hi), .err(err_hi)
    );

    segment7 #(.ACTIVE_LOW(1)) u_lo (
        .clk(clk), .rst(rst), .bcd(bcd), .en(en), .blank(blank),
        .lamp_test(lamp_test), .seg(seg_lo), .err(err_lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] glyph(input logic [3:0] d);
        logic [6:0] tbl [16];
        tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F,
`ifdef SEGMENT7_HEX_EN
                7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
`else
                7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
`endif
        return tbl[d];
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, predict the registered output, compare after the edge.
    task automatic step(input string tag, input logic [3:0] b, input logic e,
                        input logic bl, input logic lt);
        exp_t x;
        exp_t got;
        bcd = b; en = e; blank = bl; lamp_test = lt;
        if (lt)      x.seg = 7'h7F;
        else if (bl) x.seg = 7'h00;
        else         x.seg = glyph(model_digit);
        x.err = (model_digit >= 4'd10);
        sb_q.push_back(x);
        if (e) model_digit = b;
        @(posedge clk);
        #1;
        total++;
        assert (sb_q.size() > 0) else begin
            bad++;
            $error("FAIL %s_sb observed=empty expected=entry", tag);
        end
        if (sb_q.size() > 0) begin
            got = sb_q.pop_front();
            chk({tag, "_seg"},    {1'b0, seg_hi}, {1'b0, got.seg});
            chk({tag, "_err"},    {7'b0, err_hi}, {7'b0, got.err});
            chk({tag, "_seglo"},  {1'b0, seg_lo}, {1'b0, ~got.seg});
            chk({tag, "_errlo"},  {7'b0, err_lo}, {7'b0, got.err});
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; bcd = 4'd0; en = 1'b0; blank = 1'b0; lamp_test = 1'b0;
        model_digit = 4'd0;
        #2;
        chk("rst_seg",   {1'b0, seg_hi}, 8'h00);
        chk("rst_err",   {7'b0, err_hi}, 8'h00);
        chk("rst_seglo", {1'b0, seg_lo}, 8'h7F);
        #6 rst = 1'b0;
        #1;
        chk("post_rst_seg",   {1'b0, seg_hi}, 8'h00);
        chk("post_rst_seglo", {1'b0, seg_lo}, 8'h7F);

        step("first_edge", 4'd0, 1'b0, 1'b0, 1'b0);

        for (int d = 0; d < 16; d++) begin
            step($sformatf("sweep%0d", d), d[3:0], 1'b1, 1'b0, 1'b0);
        end
        step("sweep_flush", 4'd0, 1'b0, 1'b0, 1'b0);

        step("load7",  4'd7, 1'b1, 1'b0, 1'b0);
        step("hold_a", 4'd3, 1'b0, 1'b0, 1'b0);
        step("hold_b", 4'd3, 1'b0, 1'b0, 1'b0);

        step("load2",   4'd2, 1'b1, 1'b0, 1'b0);
        step("lt_bl",   4'd0, 1'b0, 1'b1, 1'b1);
        step("bl_only", 4'd0, 1'b0, 1'b1, 1'b0);
        step("show2",   4'd0, 1'b0, 1'b0, 1'b0);

        step("load4_blank", 4'd4, 1'b1, 1'b1, 1'b0);
        step("still_blank", 4'd0, 1'b0, 1'b1, 1'b0);
        step("unblank4",    4'd0, 1'b0, 1'b0, 1'b0);

        step("load8", 4'd8, 1'b1, 1'b0, 1'b0);
        step("load1", 4'd1, 1'b1, 1'b0, 1'b0);
        step("show1", 4'd0, 1'b0, 1'b0, 1'b0);

        step("load12",   4'd12, 1'b1, 1'b0, 1'b0);
        step("err_lt",   4'd0,  1'b0, 1'b0, 1'b1);
        step("err_bl",   4'd0,  1'b0, 1'b1, 1'b0);

        step("load6", 4'd6, 1'b1, 1'b0, 1'b0);
        step("show6", 4'd0, 1'b0, 1'b0, 1'b0);
        chk("pre_arst_seg", {1'b0, seg_hi}, 8'h7D);

        #2 rst = 1'b1;
        #1;
        chk("arst_seg",   {1'b0, seg_hi}, 8'h00);
        chk("arst_err",   {7'b0, err_hi}, 8'h00);
        chk("arst_seglo", {1'b0, seg_lo}, 8'h7F);
        model_digit = 4'd0;
        bcd = 4'd9; en = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_en_seg", {1'b0, seg_hi}, 8'h00);
        chk("rst_en_err", {7'b0, err_hi}, 8'h00);
        rst = 1'b0;
        en  = 1'b0;
        #1;
        step("after_arst", 4'd0, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/segment7.md
SEGMENT7 -- requirements
Module: segment7

Interface
REQ-001 The block SHALL have parameter ACTIVE_LOW, default 0: 0 = segment lit when bit is 1; 1 = all seg bits inverted at the output.
REQ-002 Port clk SHALL be an input, 1 bit: the single rising-edge clock.
REQ-003 Port rst SHALL be an input, 1 bit: asynchronous, active-high reset.
REQ-004 Port bcd SHALL be an input, 4 bits: digit code 0-15.
REQ-005 Port en SHALL be an input, 1 bit: load enable; bcd is captured when high.
REQ-006 Port blank SHALL be an input, 1 bit: forces all segments off.
REQ-007 Port lamp_test SHALL be an input, 1 bit: forces all segments on.
REQ-008 Port seg SHALL be an output, 7 bits: segment drive; seg[0]=a, seg[1]=b, ... seg[6]=g.
REQ-009 Port err SHALL be an output, 1 bit: the held code is not displayable.

Function
REQ-010 On a rising clk edge with en=1, the block SHALL store bcd in a 4-bit digit register; with en=0, the digit register SHALL hold.
REQ-011 seg and err SHALL be registered, with one-cycle latency: the output after edge N SHALL reflect the digit, blank and lamp_test values sampled at edge N.
REQ-012 Active-high patterns (gfedcba, hex) SHALL be: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
REQ-013 Output priority SHALL be: lamp_test (seg=7F), then blank (seg=00), then the decoded digit.
REQ-014 The ACTIVE_LOW inversion SHALL be applied after the priority selection.
REQ-015 err SHALL be 1 whenever the held digit is 10-15, independent of blank and lamp_test.
REQ-016 Codes 10-15 SHALL be handled per REQ-021/REQ-022.
REQ-017 If en and rst are asserted together, rst SHALL win.
REQ-018 A digit loaded while blank=1 SHALL be retained and SHALL be displayed on the cycle after blank falls.

Reset
REQ-019 While rst=1, asynchronously, the block SHALL force: digit register=0, err=0, seg=all segments off (00 if ACTIVE_LOW=0, 7F if ACTIVE_LOW=1).
REQ-020 After rst is released, seg SHALL remain off until the first clock edge, then show the pattern for digit 0 (3F, or 40 when inverted).

Configuration
REQ-021 With macro SEGMENT7_HEX_EN defined, codes 10-15 SHALL display A=77, b=7C, C=39, d=5E, E=79, F=71, and err SHALL still assert for those codes.
REQ-022 Without SEGMENT7_HEX_EN, codes 10-15 SHALL display all segments off and err SHALL assert.

Structure
REQ-023 Package segment7_pkg SHALL hold the 7-bit segment typedef, the 16 pattern constants, and the SEG_OFF and SEG_ALL constants.
REQ-024 Sub-module segment7_rom SHALL be a purely combinational 4-bit to 7-bit active-high decoder honoring SEGMENT7_HEX_EN.
REQ-025 The top module SHALL contain the registers, the priority mux and the polarity inversion.

Verification
REQ-026 With ACTIVE_LOW=0 and en=1, sweep bcd 0-15 one per cycle -> seg follows REQ-012 one cycle later (0->3F, 5->6D, 9->6F); err=1 only for 10-15; 10-15 -> 00 without the macro, 77/7C/39/5E/79/71 with it.
REQ-027 Load 7, then en=0 with bcd=3 -> seg stays 07.
REQ-028 Drive lamp_test=1 and blank=1 with digit 2 -> seg=7F. Then drop lamp_test -> seg=00. Then drop blank -> seg=5B.
REQ-029 With ACTIVE_LOW=1, load digit 8 -> seg=00; load digit 1 -> seg=79.
REQ-030 Assert rst mid-operation between clock edges while showing 6 -> seg=00 and err=0 immediately, without waiting for a clock edge; after release and one edge -> seg=3F.
